// File: rtl/pipe_reg_file_pkg.sv
// Shared types and default sizing for the pipelined register file.
package pipe_reg_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_t;
endpackage

// File: rtl/rf_fwd_mux.sv
// One read port: EX/MEM/writeback forwarding select and load-use hazard term.
module rf_fwd_mux
  import pipe_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic              used,
  input  logic [DATA_W-1:0] array_data,
  input  logic              idex_reg_write,
  input  logic [ADDR_W-1:0] idex_reg_des,
  input  logic [DATA_W-1:0] idex_data,
  input  logic              idex_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [ADDR_W-1:0] exmem_reg_des,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] data,
  output logic              hazard
);
  logic nz, idex_hit, exmem_hit, wb_hit;

  // r0 is hardwired zero, so it never matches any producer.
  assign nz        = |addr;
  assign idex_hit  = nz & idex_reg_write  & (idex_reg_des  == addr);
  assign exmem_hit = nz & exmem_reg_write & (exmem_reg_des == addr);
  assign wb_hit    = nz & wb_en           & (wb_addr       == addr);

  always_comb begin
    data = '0;
    if (run && nz) begin
      if (idex_hit)       data = idex_data;
      else if (exmem_hit) data = exmem_data;
      else if (wb_hit)    data = wb_data;
      else                data = array_data;
    end
  end

  // A load still in EX cannot supply its value yet.
  assign hazard = run & used & idex_hit & idex_mem_to_reg;
endmodule

// File: rtl/pipe_reg_file.sv
// Register file with self-clear after reset, per-port forwarding and load-use detect.
// Optional REGFILE_WB_BYPASS_EN: same-cycle writeback data forwarded to reads.
module pipe_reg_file
  import pipe_reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_used,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     idex_reg_write,
  input  logic [ADDR_W-1:0]        idex_reg_des,
  input  logic [DATA_W-1:0]        idex_data,
  input  logic                     idex_mem_to_reg,
  input  logic                     exmem_reg_write,
  input  logic [ADDR_W-1:0]        exmem_reg_des,
  input  logic [DATA_W-1:0]        exmem_data,
  output logic                     regok,
  output logic                     init_done,
  output logic [15:0]              stall_count
);
  localparam int DEPTH = 2**ADDR_W;

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run;
  logic [NUM_RD-1:0] hazard;
  logic              wb_fwd_en;

  assign run       = (state == ST_RUN);
  assign init_done = run;
  assign regok     = run & ~(|hazard);

`ifdef REGFILE_WB_BYPASS_EN
  assign wb_fwd_en = run & wr_en;
`else
  assign wb_fwd_en = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (&clr_cnt) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Clear walks one entry per cycle; writeback is locked out until it completes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!run)                     mem[clr_cnt] <= '0;
      else if (wr_en && |wr_addr)   mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                                       stall_count <= '0;
    else if (run && !regok && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_data[i*DATA_W +: DATA_W] = data;

    rf_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux (
      .run             (run),
      .addr            (addr),
      .used            (rd_used[i]),
      .array_data      (mem[addr]),
      .idex_reg_write  (idex_reg_write),
      .idex_reg_des    (idex_reg_des),
      .idex_data       (idex_data),
      .idex_mem_to_reg (idex_mem_to_reg),
      .exmem_reg_write (exmem_reg_write),
      .exmem_reg_des   (exmem_reg_des),
      .exmem_data      (exmem_data),
      .wb_en           (wb_fwd_en),
      .wb_addr         (wr_addr),
      .wb_data         (wr_data),
      .data            (data),
      .hazard          (hazard[i])
    );
  end
endmodule

// File: tb/tb_pipe_reg_file.sv
// Randomized self-checking bench for pipe_reg_file against a behavioural model.
module tb_pipe_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_used;
  logic [NR*DW-1:0]  rd_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              idex_reg_write, idex_mem_to_reg;
  logic [AW-1:0]     idex_reg_des;
  logic [DW-1:0]     idex_data;
  logic              exmem_reg_write;
  logic [AW-1:0]     exmem_reg_des;
  logic [DW-1:0]     exmem_data;
  logic              regok, init_done;
  logic [15:0]       stall_count;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model state
  logic [DW-1:0] model_mem [DEPTH];
  bit            model_run = 1'b0;
  int            init_left = DEPTH;
  int            model_stall = 0;

  pipe_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .idex_reg_write(idex_reg_write), .idex_reg_des(idex_reg_des), .idex_data(idex_data),
    .idex_mem_to_reg(idex_mem_to_reg), .exmem_reg_write(exmem_reg_write),
    .exmem_reg_des(exmem_reg_des), .exmem_data(exmem_data),
    .regok(regok), .init_done(init_done), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  function automatic int port_addr(int p);
    return int'(rd_addr[p*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] exp_read(int p);
    int a = port_addr(p);
    if (!model_run || a == 0) return '0;
    if (idex_reg_write && int'(idex_reg_des) == a) return idex_data;
    if (exmem_reg_write && int'(exmem_reg_des) == a) return exmem_data;
`ifdef REGFILE_WB_BYPASS_EN
    if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
    return model_mem[a];
  endfunction

  function automatic bit exp_regok();
    if (!model_run) return 1'b0;
    for (int p = 0; p < NR; p++)
      if (rd_used[p] && idex_reg_write && idex_mem_to_reg && port_addr(p) != 0 &&
          int'(idex_reg_des) == port_addr(p)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_port(int p, int a, bit u);
    rd_addr[p*AW +: AW] = AW'(a);
    rd_used[p] = u;
  endtask

  task automatic quiet();
    rd_addr = '0; rd_used = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    idex_reg_write = 0; idex_reg_des = '0; idex_data = '0; idex_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_reg_des = '0; exmem_data = '0;
  endtask

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic tick();
    bit ok = exp_regok();
    if (reset) begin
      model_run = 0; init_left = DEPTH; model_stall = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else if (!model_run) begin
      init_left--;
      if (init_left == 0) model_run = 1;
    end else begin
      if (!ok && model_stall != 16'hFFFF) model_stall++;
      if (wr_en && wr_addr != 0) model_mem[wr_addr] = wr_data;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    quiet(); reset = 1; tick(); reset = 0;
    vectors++;
    if (stall_count !== 16'd0) begin
      miscompares++; $display("FAIL reset_stall: got %0d want 0", stall_count);
    end
    for (int c = 0; c < DEPTH; c++) begin
      // writes and reads during clear must be ignored / read zero
      wr_en = 1; wr_addr = AW'($urandom_range(1, DEPTH-1)); wr_data = $urandom;
      set_port(0, $urandom_range(0, DEPTH-1), 1); set_port(1, $urandom_range(0, DEPTH-1), 0);
      #1;
      vectors++;
      if (init_done !== model_run || regok !== 1'b0) begin
        miscompares++; $display("FAIL init_cycle%0d: init_done=%b regok=%b want %b/0", c, init_done, regok, model_run);
      end
      vectors++;
      if (rd_data !== '0) begin
        miscompares++; $display("FAIL init_rd cycle%0d: got %h want 0", c, rd_data);
      end
      tick();
    end
    quiet(); #1;
    vectors++;
    if (init_done !== 1'b1 || regok !== 1'b1) begin
      miscompares++; $display("FAIL init_done_rise: init_done=%b regok=%b want 1/1", init_done, regok);
    end
    for (int a = 0; a < DEPTH; a += NR) begin
      for (int p = 0; p < NR; p++) set_port(p, a + p, 0);
      #1;
      for (int p = 0; p < NR; p++) begin
        vectors++;
        if (rd_data[p*DW +: DW] !== '0) begin
          miscompares++; $display("FAIL clear_read r%0d: got %h want 0", a + p, rd_data[p*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    quiet(); wr_en = 1; wr_addr = 5; wr_data = 32'h1234ABCD; tick();
    quiet(); set_port(0, 5, 1); #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h1234ABCD) begin
      miscompares++; $display("FAIL write_r5: got %h want 1234abcd", rd_data[0 +: DW]);
    end
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; tick();
    quiet(); set_port(1, 0, 1); #1;
    vectors++;
    if (rd_data[DW +: DW] !== '0) begin
      miscompares++; $display("FAIL write_r0: got %h want 0", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_forward();
    quiet(); wr_en = 1; wr_addr = 7; wr_data = 32'h11; tick();
    quiet(); set_port(0, 7, 1); set_port(1, 7, 0);
    exmem_reg_write = 1; exmem_reg_des = 7; exmem_data = 32'h22;
    idex_reg_write = 1; idex_reg_des = 7; idex_data = 32'h33; idex_mem_to_reg = 0; #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h33 || rd_data[DW +: DW] !== 32'h33 || regok !== 1'b1) begin
      miscompares++; $display("FAIL fwd_idex: got %h regok=%b want 33/33 regok=1", rd_data, regok);
    end
    idex_reg_write = 0; #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h22) begin
      miscompares++; $display("FAIL fwd_exmem: got %h want 22", rd_data[0 +: DW]);
    end
    exmem_reg_write = 0; #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h11) begin
      miscompares++; $display("FAIL fwd_array: got %h want 11", rd_data[0 +: DW]);
    end
    // forwarding to r0 is never allowed
    set_port(0, 0, 1); exmem_reg_write = 1; exmem_reg_des = 0; idex_reg_write = 1; idex_reg_des = 0; #1;
    vectors++;
    if (rd_data[0 +: DW] !== '0) begin
      miscompares++; $display("FAIL fwd_r0: got %h want 0", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_hazard();
    int base = model_stall;
    quiet(); idex_reg_write = 1; idex_reg_des = 3; idex_mem_to_reg = 1; idex_data = 32'h77;
    set_port(1, 3, 1);
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (regok !== 1'b0) begin
        miscompares++; $display("FAIL hazard_cycle%0d: regok got %b want 0", c, regok);
      end
      tick();
    end
    vectors++;
    if (int'(stall_count) != base + 4 || int'(stall_count) != model_stall) begin
      miscompares++; $display("FAIL hazard_stall: got %0d want %0d", stall_count, base + 4);
    end
    rd_used = '0; #1;
    vectors++;
    if (regok !== 1'b1) begin
      miscompares++; $display("FAIL hazard_release: regok got %b want 1", regok);
    end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] want;
    quiet(); wr_en = 1; wr_addr = 9; wr_data = 32'h5; tick();
    wr_data = 32'hA5; set_port(0, 9, 1); #1;
`ifdef REGFILE_WB_BYPASS_EN
    want = 32'hA5;
`else
    want = 32'h5;
`endif
    vectors++;
    if (rd_data[0 +: DW] !== want) begin
      miscompares++; $display("FAIL same_cycle_r9: got %h want %h", rd_data[0 +: DW], want);
    end
    tick(); quiet(); set_port(0, 9, 0); #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'hA5) begin
      miscompares++; $display("FAIL after_write_r9: got %h want a5", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wr_en = 1'($urandom); wr_addr = AW'($urandom_range(0, 7)); wr_data = $urandom;
      idex_reg_write = 1'($urandom); idex_reg_des = AW'($urandom_range(0, 7));
      idex_data = $urandom; idex_mem_to_reg = ($urandom_range(0, 3) == 0);
      exmem_reg_write = 1'($urandom); exmem_reg_des = AW'($urandom_range(0, 7)); exmem_data = $urandom;
      for (int p = 0; p < NR; p++) set_port(p, $urandom_range(0, 7), 1'($urandom));
      #1;
      for (int p = 0; p < NR; p++) begin
        vectors++;
        if (rd_data[p*DW +: DW] !== exp_read(p)) begin
          miscompares++; $display("FAIL rand_rd c%0d p%0d a%0d: got %h want %h", c, p, port_addr(p), rd_data[p*DW +: DW], exp_read(p));
        end
      end
      vectors++;
      if (regok !== exp_regok() || int'(stall_count) != model_stall) begin
        miscompares++; $display("FAIL rand_ctl c%0d: regok=%b stall=%0d want %b/%0d", c, regok, stall_count, exp_regok(), model_stall);
      end
      tick();
    end
  endtask

  task automatic test_reset_restart();
    quiet(); reset = 1; tick(); reset = 0;
    for (int c = 0; c < 10; c++) tick();
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < DEPTH; c++) begin
      vectors++;
      if (init_done !== 1'b0) begin
        miscompares++; $display("FAIL restart_init c%0d: init_done got %b want 0", c, init_done);
      end
      tick();
    end
    vectors++;
    if (init_done !== 1'b1) begin
      miscompares++; $display("FAIL restart_done: init_done got %b want 1", init_done);
    end
    // populate, stall a little, then reset from RUN
    wr_en = 1; wr_addr = 12; wr_data = 32'hDEAD; tick();
    quiet(); idex_reg_write = 1; idex_reg_des = 4; idex_mem_to_reg = 1; set_port(0, 4, 1);
    tick(); tick();
    quiet(); reset = 1; tick(); reset = 0;
    vectors++;
    if (stall_count !== 16'd0 || init_done !== 1'b0) begin
      miscompares++; $display("FAIL run_reset: stall=%0d init_done=%b want 0/0", stall_count, init_done);
    end
    for (int c = 0; c < DEPTH; c++) tick();
    set_port(0, 12, 0); #1;
    vectors++;
    if (rd_data[0 +: DW] !== '0 || init_done !== 1'b1) begin
      miscompares++; $display("FAIL run_reset_clear: r12=%h init_done=%b want 0/1", rd_data[0 +: DW], init_done);
    end
  endtask

  initial begin
    quiet(); reset = 1;
    test_reset();
    test_write_read();
    test_forward();
    test_hazard();
    test_same_cycle();
    test_random();
    test_reset_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
